pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and drives the instruction-memory request interface. It issues one fetch at a time, advances the PC by 4 on each accepted request, and redirects to the branch target on a taken conditional or an unconditional branch. It holds a fetched instruction while the decode stage stalls, and discards in-flight responses on a redirect. It sits between the instruction memory and the decode stage and replaces the free-running combinational PC update.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 0, PC value loaded on reset
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
stall_i  in  1  decode not ready; held instruction must not be consumed
br_valid_i  in  1  branch resolution strobe, one cycle
branch_i  in  1  conditional branch flag, qualified by br_valid_i
uncondbranch_i  in  1  unconditional branch flag, qualified by br_valid_i
zero_i  in  1  ALU zero flag, qualified by br_valid_i
br_pc_i  in  ADDR_W  PC of the resolving branch instruction
sign_extend_i  in  32  sign-extended word offset
imem_req_o  out  1  fetch request
imem_addr_o  out  ADDR_W  fetch address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid; earliest one cycle after gnt
imem_rdata_i  in  INSTR_W  response data
instr_valid_o  out  1  instruction available to decode
instr_o  out  INSTR_W  instruction
instr_pc_o  out  ADDR_W  address of instr_o
pc_o  out  ADDR_W  address of next fetch

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, pc_o=RESET_PC, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, kill=0.
- take = br_valid_i & ((branch_i & zero_i) | uncondbranch_i).
- target = br_pc_i + (sign_extend_i << 2), truncated to ADDR_W, wrapping modulo 2^ADDR_W.
- Only one request is outstanding. imem_addr_o = pc_o whenever imem_req_o=1.
- IDLE: entered only from reset. Moves to FETCH on the next cycle.
- FETCH: imem_req_o=1.
  - On gnt: pc_o <= pc_o+4, capture req_pc=pc_o, go to WAIT.
  - On take without gnt: pc_o <= target and stay in FETCH. The address changes next cycle, which is the only permitted address change while req is high.
  - On take with gnt: pc_o <= target, kill <= 1, go to WAIT.
- WAIT: imem_req_o=0.
  - On rvalid with kill=1: drop the data, kill <= 0, go to FETCH.
  - On rvalid with kill=0: instr_o <= rdata, instr_pc_o <= req_pc, instr_valid_o <= 1, go to HOLD.
  - On take (any cycle): pc_o <= target, kill <= 1. If take arrives in the same cycle as rvalid, the data is dropped.
- HOLD: instr_valid_o=1 and instr_o/instr_pc_o stable.
  - Consume when instr_valid_o & !stall_i: instr_valid_o <= 0 next cycle, go to FETCH. Back-to-back throughput is one instruction per 3 cycles with zero-wait memory.
  - On take: instr_valid_o <= 0, pc_o <= target, go to FETCH, whether or not stall_i is high. Redirect has priority over stall and consume.
- A redirect is never lost. A second take before the refetch overwrites the target (last wins).
- Reset asserted mid-transaction: all state returns to reset values immediately. A late rvalid after reset release must be ignored while in IDLE/FETCH.
- rvalid outside WAIT is ignored.
- PC increment wraps from 2^ADDR_W-4 to 0.

Decomposition:
- Shared package pc_pkg: state enum (IDLE, FETCH, WAIT, HOLD), constants PC_INC=4 and BR_SHIFT=2.
- One natural sub-module, pc_target_calc (combinational take/target logic), reusable by the execute stage.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after gnt, stall 0 -> imem_addr_o sequence 0,4,8; instr_pc_o 0,4,8; instr_valid_o high one cycle per 3-cycle fetch.
- Instruction in HOLD at PC 0x8 with stall_i=1 for 5 cycles -> instr_o/instr_pc_o stable, no imem_req_o; stall drops -> next request at 0xC.
- br_valid_i, branch_i=1, zero_i=1, br_pc_i=0x10, sign_extend_i=0xFFFFFFFE, in WAIT -> pending response dropped (no instr_valid_o), next imem_addr_o=0x08.
- branch_i=1, zero_i=0 -> no redirect, fetch continues sequentially. uncondbranch_i=1 with br_pc_i=0x20, offset 3 -> next fetch at 0x2C.
- Redirect in FETCH while gnt=0 for 3 cycles -> imem_addr_o switches to target the next cycle and holds it until gnt.
- rst_n asserted in WAIT, late rvalid after release -> ignored; first fetch at RESET_PC.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch sequencer.
//   state_e  : fetch FSM states (IDLE, FETCH, WAIT, HOLD)
//   PC_INC   : byte increment between sequential fetches
//   BR_SHIFT : word-offset to byte-offset shift for branch targets
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned BR_SHIFT = 2;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus.
//   req    : fetch request          (master -> slave)
//   addr   : fetch address          (master -> slave)
//   gnt    : request accepted       (slave  -> master)
//   rvalid : response data valid    (slave  -> master)
//   rdata  : response instruction   (slave  -> master)
interface pc_fetch_ctrl_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/pc_target_calc.sv
// Branch resolution helper: decides whether a resolving branch redirects
// fetch and computes its target.
//   br_valid_i     : resolution strobe qualifying the flags below
//   branch_i       : conditional branch, taken when zero_i is set
//   uncondbranch_i : unconditional branch
//   zero_i         : ALU zero flag
//   br_pc_i        : PC of the resolving branch
//   sign_extend_i  : signed word offset
//   take_o         : redirect fetch this cycle
//   target_o       : br_pc_i + offset*4, wrapping modulo 2^ADDR_W
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              br_valid_i,
  input  logic              branch_i,
  input  logic              uncondbranch_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [31:0]       sign_extend_i,
  output logic              take_o,
  output logic [ADDR_W-1:0] target_o
);

  logic [31:0] offset_bytes;

  always_comb begin
    offset_bytes = sign_extend_i << BR_SHIFT;
    take_o       = br_valid_i & ((branch_i & zero_i) | uncondbranch_i);
    // The signed cast keeps negative offsets correct if ADDR_W exceeds 32.
    target_o     = br_pc_i + ADDR_W'($signed(offset_bytes));
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a
// time, holds the fetched instruction while decode stalls, and redirects on
// taken branches (discarding any response that is still in flight).
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall_i         : decode not ready
//   br_*/branch_i/uncondbranch_i/zero_i/sign_extend_i : branch resolution
//   imem            : instruction-memory bus (master side)
//   instr_valid_o   : instruction available to decode
//   instr_o         : held instruction
//   instr_pc_o      : address of instr_o
//   pc_o            : address of the next fetch
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       INSTR_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                br_valid_i,
  input  logic                branch_i,
  input  logic                uncondbranch_i,
  input  logic                zero_i,
  input  logic [ADDR_W-1:0]   br_pc_i,
  input  logic [31:0]         sign_extend_i,
  pc_fetch_ctrl_if.master     imem,
  output logic                instr_valid_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [ADDR_W-1:0]   instr_pc_o,
  output logic [ADDR_W-1:0]   pc_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                kill_q, kill_d;

  logic                take;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   pc_inc;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_target_calc (
    .br_valid_i     (br_valid_i),
    .branch_i       (branch_i),
    .uncondbranch_i (uncondbranch_i),
    .zero_i         (zero_i),
    .br_pc_i        (br_pc_i),
    .sign_extend_i  (sign_extend_i),
    .take_o         (take),
    .target_o       (target)
  );

  // Wraps naturally from 2^ADDR_W-4 to 0.
  assign pc_inc = pc_q + ADDR_W'(PC_INC);

  // State register.
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      instr_pc_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      kill_q        <= kill_d;
    end
  end

  // Next-state logic. A taken branch always lands in pc_d, so a redirect is
  // never lost and a later one simply overwrites an earlier one.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    instr_pc_d    = instr_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    kill_d        = kill_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (take) pc_d = target;
      end

      FETCH: begin
        if (take) begin
          pc_d = target;
          if (imem.gnt) begin
            // The granted request belongs to the old path; drop its response.
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (imem.gnt) begin
          pc_d     = pc_inc;
          req_pc_d = pc_q;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (take) pc_d = target;
        if (imem.rvalid) begin
          // Response closes the transaction; nothing is left in flight.
          kill_d  = 1'b0;
          state_d = FETCH;
          if (!kill_q && !take) begin
            instr_d       = imem.rdata;
            instr_pc_d    = req_pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (take) begin
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        // Redirect wins over both stall and consume.
        if (take) begin
          pc_d          = target;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (!stall_i) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs. The address only moves while req is high when pc_q is
  // redirected in FETCH.
  always_comb begin
    imem.req  = (state_q == FETCH);
    imem.addr = pc_q;
  end

  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by a randomized run
// against a transaction-level model of the fetch stream.
module tb_pc_fetch_ctrl;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_valid, branch, uncond, zero;
  logic [31:0] br_pc, sign_ext;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, pc;

  pc_fetch_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_bus ();

  pc_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .INSTR_W(INSTR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .br_valid_i     (br_valid),
    .branch_i       (branch),
    .uncondbranch_i (uncond),
    .zero_i         (zero),
    .br_pc_i        (br_pc),
    .sign_extend_i  (sign_ext),
    .imem           (imem_bus),
    .instr_valid_o  (instr_valid),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .pc_o           (pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory responder knobs and state.
  int unsigned gnt_pct   = 100;
  int unsigned rv_dly_min = 0;
  int unsigned rv_dly_max = 0;
  bit          inject_rv = 1'b0;
  bit          mem_busy  = 1'b0;
  int unsigned mem_cnt   = 0;
  logic [31:0] mem_addr  = '0;
  bit          cur_gnt, cur_rv;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Drives gnt/rvalid/rdata for the current cycle (called at a negedge).
  task automatic drive_mem();
    logic [31:0] rd;
    cur_rv = 1'b0;
    rd     = '0;
    if (!rst_n) mem_busy = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        cur_rv   = 1'b1;
        rd       = mem_data(mem_addr);
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (inject_rv) begin
      cur_rv = 1'b1;
      rd     = 32'hBAD0_BAD0;
    end
    cur_gnt = ($urandom_range(99) < gnt_pct);
    if (rst_n && imem_bus.req && cur_gnt) begin
      mem_busy = 1'b1;
      mem_addr = imem_bus.addr;
      mem_cnt  = $urandom_range(rv_dly_max, rv_dly_min);
    end
    imem_bus.gnt    = cur_gnt;
    imem_bus.rvalid = cur_rv;
    imem_bus.rdata  = rd;
  endtask

  task automatic step();
    drive_mem();
    @(negedge clk);
  endtask

  task automatic set_br(input logic v, input logic b, input logic u, input logic z,
                        input logic [31:0] bpc, input logic [31:0] se);
    br_valid = v; branch = b; uncond = u; zero = z; br_pc = bpc; sign_ext = se;
  endtask

  task automatic clear_br();
    set_br(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++; if (imem_bus.req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", imem_bus.req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    n_cmp++; if (pc !== RESET_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    gnt_pct = 100; rv_dly_min = 0; rv_dly_max = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] req_addrs[$];
    logic [31:0] vld_pcs[$];
    int          vld_cyc[$];
    for (int c = 1; c <= 9; c++) begin
      step();
      if (imem_bus.req) req_addrs.push_back(imem_bus.addr);
      if (instr_valid) begin
        vld_pcs.push_back(instr_pc);
        vld_cyc.push_back(c);
        n_cmp++; if (instr !== mem_data(instr_pc)) begin n_err++; $display("FAIL seq_data: got %h want %h", instr, mem_data(instr_pc)); end
      end
    end
    n_cmp++; if (req_addrs.size() != 3) begin n_err++; $display("FAIL seq_req_count: got %0d want 3", req_addrs.size()); end
    n_cmp++; if (vld_pcs.size() != 3) begin n_err++; $display("FAIL seq_valid_count: got %0d want 3", vld_pcs.size()); end
    for (int i = 0; i < 3 && i < req_addrs.size(); i++) begin
      n_cmp++; if (req_addrs[i] !== 32'(4 * i)) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", i, req_addrs[i], 32'(4 * i)); end
    end
    for (int i = 0; i < 3 && i < vld_pcs.size(); i++) begin
      n_cmp++; if (vld_pcs[i] !== 32'(4 * i)) begin n_err++; $display("FAIL seq_instr_pc[%0d]: got %h want %h", i, vld_pcs[i], 32'(4 * i)); end
    end
    for (int i = 1; i < vld_cyc.size(); i++) begin
      n_cmp++; if (vld_cyc[i] - vld_cyc[i-1] != 3) begin n_err++; $display("FAIL seq_period: got %0d want 3", vld_cyc[i] - vld_cyc[i-1]); end
    end
  endtask

  task automatic test_stall();
    bit ok = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== mem_data(32'h8) || imem_bus.req !== 1'b0) begin
        ok = 1'b0;
        $display("FAIL stall_hold: cyc %0d valid=%0b pc=%h instr=%h req=%0b want 1/00000008/%h/0",
                 i, instr_valid, instr_pc, instr, imem_bus.req, mem_data(32'h8));
      end
    end
    n_cmp++; if (!ok) n_err++;
    stall = 1'b0;
    step();
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'hC) begin n_err++; $display("FAIL stall_release: req=%0b addr=%h want 1/0000000c", imem_bus.req, imem_bus.addr); end
  endtask

  task automatic test_branch_in_wait();
    bit seen_valid = 1'b0;
    bit found = 1'b0;
    rv_dly_min = 2; rv_dly_max = 2;
    step();
    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFE);
    step();
    clear_br();
    n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL wait_br_pc: got %h want 00000008", pc); end
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (instr_valid) seen_valid = 1'b1;
      if (imem_bus.req) found = 1'b1;
    end
    n_cmp++; if (seen_valid) begin n_err++; $display("FAIL wait_br_drop: got valid=1 want no delivery"); end
    n_cmp++; if (!found || imem_bus.addr !== 32'h8) begin n_err++; $display("FAIL wait_br_refetch: req=%0b addr=%h want 1/00000008", found, imem_bus.addr); end
    rv_dly_min = 0; rv_dly_max = 0;
  endtask

  task automatic test_not_taken_uncond();
    set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h5);
    step();
    clear_br();
    n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL not_taken_pc: got %h want 0000000c", pc); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin n_err++; $display("FAIL not_taken_deliver: valid=%0b pc=%h want 1/00000008", instr_valid, instr_pc); end
    set_br(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h3);
    stall = 1'b1;
    step();
    clear_br();
    stall = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL uncond_valid: got %0b want 0", instr_valid); end
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h2C) begin n_err++; $display("FAIL uncond_addr: req=%0b addr=%h want 1/0000002c", imem_bus.req, imem_bus.addr); end
  endtask

  task automatic test_redirect_no_gnt();
    gnt_pct = 0;
    set_br(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h10);
    step();
    clear_br();
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h140) begin n_err++; $display("FAIL nognt_switch: req=%0b addr=%h want 1/00000140", imem_bus.req, imem_bus.addr); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h140) begin n_err++; $display("FAIL nognt_hold: req=%0b addr=%h want 1/00000140", imem_bus.req, imem_bus.addr); end
    end
    gnt_pct = 100;
    step();
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h140 || instr !== mem_data(32'h140)) begin
      n_err++; $display("FAIL nognt_deliver: valid=%0b pc=%h instr=%h want 1/00000140/%h", instr_valid, instr_pc, instr, mem_data(32'h140));
    end
    step();
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h144) begin n_err++; $display("FAIL nognt_next: req=%0b addr=%h want 1/00000144", imem_bus.req, imem_bus.addr); end
  endtask

  task automatic test_wrap();
    gnt_pct = 0;
    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h3);
    step();
    clear_br();
    n_cmp++; if (imem_bus.addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target: got %h want fffffffc", imem_bus.addr); end
    gnt_pct = 100;
    step();
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
    step();
    n_cmp++; if (instr_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_instr_pc: got %h want fffffffc", instr_pc); end
    step();
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: req=%0b addr=%h want 1/00000000", imem_bus.req, imem_bus.addr); end
  endtask

  task automatic test_reset_mid();
    rv_dly_min = 2; rv_dly_max = 2;
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_bus.req !== 1'b0 || pc !== RESET_PC || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_async: req=%0b pc=%h valid=%0b want 0/%h/0", imem_bus.req, pc, instr_valid, RESET_PC);
    end
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    rv_dly_min = 0; rv_dly_max = 0;
    inject_rv = 1'b1;
    step();
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== RESET_PC || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_first: req=%0b addr=%h valid=%0b want 1/%h/0", imem_bus.req, imem_bus.addr, instr_valid, RESET_PC);
    end
    gnt_pct = 0;
    step();
    inject_rv = 1'b0;
    n_cmp++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== RESET_PC || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_late_rv: req=%0b addr=%h valid=%0b want 1/%h/0", imem_bus.req, imem_bus.addr, instr_valid, RESET_PC);
    end
    gnt_pct = 100;
    step();
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== mem_data(RESET_PC)) begin
      n_err++; $display("FAIL midreset_deliver: valid=%0b pc=%h instr=%h want 1/%h/%h", instr_valid, instr_pc, instr, RESET_PC, mem_data(RESET_PC));
    end
  endtask

  // Model: pc_o is always the next address the fetch stream will request;
  // delivered instructions are exactly the granted addresses whose response
  // arrived with no redirect since the grant.
  task automatic test_random();
    logic [31:0] exp_fetch;
    logic [31:0] pend_addr;
    bit          pend_live;
    logic [31:0] dq[$];
    bit          s_req, s_valid, take;
    logic [31:0] s_addr, target;
    int          se_int;
    int          delivered = 0;
    int          wraps = 0;

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_fetch = RESET_PC;
    pend_live = 1'b0;
    pend_addr = '0;
    gnt_pct = 60; rv_dly_min = 0; rv_dly_max = 3;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      s_req   = imem_bus.req;
      s_addr  = imem_bus.addr;
      s_valid = instr_valid;

      n_cmp++; if (pc !== exp_fetch) begin n_err++; $display("FAIL rnd_pc: cyc %0d got %h want %h", cyc, pc, exp_fetch); end
      if (s_req) begin
        n_cmp++; if (s_addr !== exp_fetch) begin n_err++; $display("FAIL rnd_addr: cyc %0d got %h want %h", cyc, s_addr, exp_fetch); end
        n_cmp++; if (s_valid) begin n_err++; $display("FAIL rnd_req_and_valid: cyc %0d got valid=1 with req=1 want 0", cyc); end
      end
      if (s_valid) begin
        n_cmp++;
        if (dq.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious: cyc %0d got valid pc=%h want no instruction", cyc, instr_pc);
        end else if (instr_pc !== dq[0] || instr !== mem_data(dq[0])) begin
          n_err++; $display("FAIL rnd_deliver: cyc %0d got pc=%h instr=%h want %h/%h", cyc, instr_pc, instr, dq[0], mem_data(dq[0]));
        end
      end

      stall  = ($urandom_range(2) == 0);
      branch = $urandom_range(1) == 1;
      uncond = $urandom_range(3) == 0;
      zero   = $urandom_range(1) == 1;
      br_valid = ($urandom_range(7) == 0);
      br_pc  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : {$urandom() >> 2, 2'b00};
      se_int = int'($urandom_range(16)) - 8;
      sign_ext = 32'(se_int);

      drive_mem();

      take   = br_valid && ((branch && zero) || uncond);
      target = br_pc + 32'(se_int * 4);

      if (s_req && cur_gnt) begin
        pend_live = !take;
        pend_addr = s_addr;
        exp_fetch = s_addr + 32'd4;
        if (s_addr == 32'hFFFF_FFFC) wraps++;
      end
      if (cur_rv) begin
        if (pend_live && !take) dq.push_back(pend_addr);
        pend_live = 1'b0;
      end else if (take) begin
        pend_live = 1'b0;
      end
      if (s_valid && (take || !stall) && dq.size() > 0) begin
        void'(dq.pop_front());
        delivered++;
      end
      if (take) exp_fetch = target;

      @(negedge clk);
    end
    clear_br();
    stall = 1'b0;
    n_cmp++; if (delivered < 200) begin n_err++; $display("FAIL rnd_progress: got %0d deliveries want >= 200", delivered); end
    n_cmp++; if (wraps < 1) begin n_err++; $display("FAIL rnd_wrap_seen: got %0d wraps want >= 1", wraps); end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    clear_br();
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch_in_wait();
    test_not_taken_uncond();
    test_redirect_no_gnt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
